toggle_hs_responder: RTL and testbench
======================================

Name: toggle_hs_responder

Overview:
- Responder end of a two-phase (toggle) request/acknowledge link.
- The initiator presents data and toggles req_tog. This block detects the toggle, presents the data on a valid/ready output, and toggles ack_tog once the data is consumed.
- Pairs with the team's T-FF style toggle generators. Sits between a toggle-signalling producer and a streaming consumer.

Parameters:
- WIDTH, 8: width of data_in / out_data.
- SYNC_STAGES, 2: synchronizer flops on req_tog; legal range 2-4.
- CNT_W, 16: width of the completed-transfer counter.

Ports:
- clk  input  1  clock, all logic on rising edge.
- rst  input  1  reset, synchronous, active-high.
- req_tog  input  1  request toggle from initiator; each level change is one request.
- data_in  input  WIDTH  request payload; initiator holds it stable from its toggle until it sees ack_tog change.
- ack_tog  output  1  acknowledge toggle back to initiator.
- out_valid  output  1  payload available.
- out_data  output  WIDTH  captured payload.
- out_ready  input  1  consumer accepts when out_valid&&out_ready.
- xfer_count  output  CNT_W  completed transfers, wraps modulo 2^CNT_W.
- overrun  output  1  sticky protocol-violation flag.

Behaviour:
- Reset (rst=1 at a clk edge) forces:
  - ack_tog=0, out_valid=0, out_data=0, xfer_count=0, overrun=0.
  - All synchronizer flops and the edge-history flop = 0.
  - FSM=IDLE.
  - Applies mid-transfer too: any pending payload is discarded and no ack is issued. The initiator is also required to reset req_tog to 0.
- Edge detect: req_s is the last synchronizer stage and req_d is req_s delayed one cycle. req_edge = req_s ^ req_d.
- Latency: toggle of req_tog before edge N gives req_edge at edge N+SYNC_STAGES and out_valid=1 after edge N+SYNC_STAGES+1 (3 cycles for default).
- FSM states:
  - IDLE: out_valid=0. On req_edge, capture data_in into out_data, set out_valid=1, go to HOLD.
  - HOLD: out_valid=1 and out_data stable. On out_valid&&out_ready, clear out_valid, invert ack_tog, increment xfer_count (all at the same edge), and go to IDLE.
- Back-to-back: a req_edge in the same cycle as the HOLD->IDLE transfer cannot occur under the legal protocol (initiator waits for ack). If it does occur, it is treated as an overrun (below).
- Legal sequence throughput: at most one transfer per round trip. There is no buffering beyond the single out_data register.
- xfer_count wraps from 2^CNT_W-1 to 0 with no flag.
- out_ready while out_valid=0 is ignored.

Optional Feature:
- Macro: TOGGLE_HS_OVERRUN_DET_EN.
- Defined:
  - A req_edge while the FSM is in HOLD sets overrun=1, sticky until rst.
  - The offending request is dropped. out_data is not overwritten and no extra ack toggle is issued.
- Undefined:
  - overrun is tied to 0.
  - An edge seen in HOLD is still dropped silently with out_data unchanged.
  - Detection logic is not synthesized.

Decomposition:
- Package toggle_hs_pkg holds:
  - the state typedef (IDLE, HOLD, 1-bit encoding);
  - default constants WIDTH_DEF=8, SYNC_STAGES_DEF=2, CNT_W_DEF=16.
- Sub-module sync_toggle_detect (param SYNC_STAGES): clk, rst, async_in -> edge_pulse. It is the synchronizer chain plus XOR edge detect, reusable by the matching initiator for ack_tog.
- Top holds the FSM, data register, counter and overrun logic.

Test Plan:
- Reset mid-HOLD: rst=1 for one cycle while out_valid=1 -> next cycle out_valid=0, ack_tog=0, xfer_count=0, overrun=0. No ack ever issued for the dropped request.
- Single transfer: after reset, data_in=0xA5 and req_tog 0->1 at cycle 0 with out_ready=1 held high -> out_valid=1, out_data=0xA5 at cycle 3. ack_tog=1, out_valid=0, xfer_count=1 at cycle 4.
- Backpressure: out_ready=0 for 10 cycles after out_valid rises, with data_in changed to 0x3C in that window -> out_data stays 0xA5 and ack_tog is unchanged. One cycle after out_ready=1, ack_tog toggles.
- Repeated protocol: the initiator model toggles again only after seeing ack, for 20 requests with data 0..19 -> 20 outputs in order, xfer_count=20, ack_tog=0, overrun=0.
- Overrun, macro defined: toggle req_tog twice while held in HOLD with out_ready=0 -> overrun=1 and stays 1, out_data unchanged. After out_ready=1, exactly one ack toggle and xfer_count+1. Macro undefined: same stimulus gives overrun=0.
- Counter wrap, CNT_W=4: 17 legal transfers -> xfer_count=1.

Source files
------------

// File: rtl/toggle_hs_pkg.sv
// rtl/toggle_hs_pkg.sv - shared state type and default parameters for toggle_hs_responder
package toggle_hs_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        HOLD = 1'b1
    } state_t;

    localparam int WIDTH_DEF       = 8;
    localparam int SYNC_STAGES_DEF = 2;
    localparam int CNT_W_DEF       = 16;

endpackage

// File: rtl/sync_toggle_detect.sv
// rtl/sync_toggle_detect.sv - synchronizer chain plus XOR edge detect for a toggle signal
module sync_toggle_detect #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic async_in,
    output logic edge_pulse
);

    logic [SYNC_STAGES-1:0] sync_q, sync_d;
    logic                   hist_q, hist_d;

    // Shift the raw toggle through the chain; the history flop holds the previous synchronized level.
    always_comb begin
        sync_d = {sync_q[SYNC_STAGES-2:0], async_in};
        hist_d = sync_q[SYNC_STAGES-1];
    end

    // Chain and history registers, cleared on reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync_q <= '0;
            hist_q <= 1'b0;
        end else begin
            sync_q <= sync_d;
            hist_q <= hist_d;
        end
    end

    // Any level change of the synchronized toggle is one event.
    assign edge_pulse = sync_q[SYNC_STAGES-1] ^ hist_q;

endmodule

// File: rtl/toggle_hs_responder.sv
// rtl/toggle_hs_responder.sv - two-phase toggle responder feeding a valid/ready stream; option TOGGLE_HS_OVERRUN_DET_EN
module toggle_hs_responder
    import toggle_hs_pkg::*;
#(
    parameter int WIDTH       = WIDTH_DEF,
    parameter int SYNC_STAGES = SYNC_STAGES_DEF,
    parameter int CNT_W       = CNT_W_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req_tog,
    input  logic [WIDTH-1:0] data_in,
    output logic             ack_tog,
    output logic             out_valid,
    output logic [WIDTH-1:0] out_data,
    input  logic             out_ready,
    output logic [CNT_W-1:0] xfer_count,
    output logic             overrun
);

    state_t           state_q, state_d;
    logic [WIDTH-1:0] data_q, data_d;
    logic             ack_q, ack_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             req_edge;

    sync_toggle_detect #(
        .SYNC_STAGES(SYNC_STAGES)
    ) u_sync (
        .clk       (clk),
        .rst       (rst),
        .async_in  (req_tog),
        .edge_pulse(req_edge)
    );

    // Capture on a new request in IDLE; on consumer handshake in HOLD, ack and count together.
    always_comb begin
        state_d = state_q;
        data_d  = data_q;
        ack_d   = ack_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: begin
                if (req_edge) begin
                    data_d  = data_in;
                    state_d = HOLD;
                end
            end
            HOLD: begin
                // A request edge here is dropped: data_q is left untouched.
                if (out_ready) begin
                    ack_d   = ~ack_q;
                    cnt_d   = cnt_q + CNT_W'(1);
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State, payload, ack and counter registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            data_q  <= '0;
            ack_q   <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            data_q  <= data_d;
            ack_q   <= ack_d;
            cnt_q   <= cnt_d;
        end
    end

`ifdef TOGGLE_HS_OVERRUN_DET_EN
    logic ovr_q, ovr_d;

    // Sticky flag: a request arriving while the previous one is still held.
    always_comb begin
        ovr_d = ovr_q;
        if (state_q == HOLD && req_edge) begin
            ovr_d = 1'b1;
        end
    end

    // Overrun register, only cleared by reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            ovr_q <= 1'b0;
        end else begin
            ovr_q <= ovr_d;
        end
    end

    assign overrun = ovr_q;
`else
    assign overrun = 1'b0;
`endif

    assign ack_tog    = ack_q;
    assign out_valid  = (state_q == HOLD);
    assign out_data   = data_q;
    assign xfer_count = cnt_q;

endmodule

// File: tb/tb_toggle_hs_responder.sv
// tb/tb_toggle_hs_responder.sv - self-checking bench for toggle_hs_responder
module tb_toggle_hs_responder;

`ifdef TOGGLE_HS_OVERRUN_DET_EN
    localparam logic OVR_EN = 1'b1;
`else
    localparam logic OVR_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic        req_tog;
    logic [7:0]  data_in;
    logic        out_ready;
    logic        ack_tog, out_valid, overrun;
    logic [7:0]  out_data;
    logic [15:0] xfer_count;
    logic        ack4, valid4, ovr4;
    logic [7:0]  data4;
    logic [3:0]  cnt4;

    int          n_cmp = 0;
    int          n_err = 0;
    logic [7:0]  exp_q[$];
    int          exp_cnt;
    logic        exp_ack;

    typedef struct {
        logic [7:0] data;
        int         delay;
        logic [7:0] exp_data;
        int         exp_cnt;
    } vec_t;
    vec_t vecs[20];

    always #5 clk = ~clk;

    toggle_hs_responder #(.WIDTH(8), .SYNC_STAGES(2), .CNT_W(16)) dut (
        .clk(clk), .rst(rst), .req_tog(req_tog), .data_in(data_in),
        .ack_tog(ack_tog), .out_valid(out_valid), .out_data(out_data),
        .out_ready(out_ready), .xfer_count(xfer_count), .overrun(overrun)
    );

    toggle_hs_responder #(.WIDTH(8), .SYNC_STAGES(2), .CNT_W(4)) dut4 (
        .clk(clk), .rst(rst), .req_tog(req_tog), .data_in(data_in),
        .ack_tog(ack4), .out_valid(valid4), .out_data(data4),
        .out_ready(out_ready), .xfer_count(cnt4), .overrun(ovr4)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_valid();
        for (int i = 0; i < 20 && !out_valid; i++) tick();
        check("valid_timeout", {31'b0, out_valid}, 32'd1);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        req_tog = 1'b0;
        out_ready = 1'b0;
        exp_q.delete();
        tick();
        rst = 1'b0;
        exp_cnt = 0;
        exp_ack = 1'b0;
    endtask

    task automatic do_xfer(input logic [7:0] d, input int delay, input logic [7:0] exp_d, input int exp_c);
        data_in = d;
        req_tog = ~req_tog;
        exp_q.push_back(d);
        wait_valid();
        repeat (delay) tick();
        check("hold_data", {24'b0, out_data}, {24'b0, exp_d});
        check("hold_ack", {31'b0, ack_tog}, {31'b0, exp_ack});
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        exp_cnt++;
        exp_ack = ~exp_ack;
        check("xfer_ack", {31'b0, ack_tog}, {31'b0, exp_ack});
        check("xfer_cnt", {16'b0, xfer_count}, exp_c);
    endtask

    // Scoreboard: every accepted output must match the oldest outstanding request.
    always @(negedge clk) begin
        if (!rst && out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                n_cmp++;
                n_err++;
                $display("FAIL sb_underflow: got 0x%0h with no request outstanding", out_data);
            end else begin
                automatic logic [7:0] e = exp_q.pop_front();
                check("sb_data", {24'b0, out_data}, {24'b0, e});
            end
        end
    end

    initial begin
        for (int i = 0; i < 20; i++) begin
            vecs[i].data     = 8'(i);
            vecs[i].delay    = i % 4;
            vecs[i].exp_data = 8'(i);
            vecs[i].exp_cnt  = i + 1;
        end
        data_in = 8'h00;
        rst = 1'b1;
        req_tog = 1'b0;
        out_ready = 1'b0;
        tick();
        tick();
        do_reset();

        check("rst_valid", {31'b0, out_valid}, 32'd0);
        check("rst_ack", {31'b0, ack_tog}, 32'd0);
        check("rst_data", {24'b0, out_data}, 32'd0);
        check("rst_cnt", {16'b0, xfer_count}, 32'd0);
        check("rst_ovr", {31'b0, overrun}, 32'd0);

        // Single transfer with out_ready held high: valid after 3 edges, ack on the 4th.
        data_in = 8'hA5;
        out_ready = 1'b1;
        req_tog = 1'b1;
        exp_q.push_back(8'hA5);
        tick();
        tick();
        check("lat_early", {31'b0, out_valid}, 32'd0);
        tick();
        check("lat_valid", {31'b0, out_valid}, 32'd1);
        check("lat_data", {24'b0, out_data}, 32'hA5);
        tick();
        exp_cnt = 1;
        exp_ack = 1'b1;
        check("single_ack", {31'b0, ack_tog}, 32'd1);
        check("single_valid", {31'b0, out_valid}, 32'd0);
        check("single_cnt", {16'b0, xfer_count}, 32'd1);
        out_ready = 1'b0;

        // Backpressure: payload and ack frozen while the consumer stalls.
        data_in = 8'hA5;
        req_tog = ~req_tog;
        exp_q.push_back(8'hA5);
        wait_valid();
        data_in = 8'h3C;
        repeat (10) tick();
        check("bp_data", {24'b0, out_data}, 32'hA5);
        check("bp_ack", {31'b0, ack_tog}, 32'd1);
        check("bp_valid", {31'b0, out_valid}, 32'd1);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        exp_cnt = 2;
        exp_ack = 1'b0;
        check("bp_ack_after", {31'b0, ack_tog}, 32'd0);
        check("bp_cnt", {16'b0, xfer_count}, 32'd2);

        // Table-driven repeated protocol; the narrow-counter instance wraps at transfer 16.
        do_reset();
        for (int i = 0; i < 20; i++) begin
            do_xfer(vecs[i].data, vecs[i].delay, vecs[i].exp_data, vecs[i].exp_cnt);
            if (i == 16) check("wrap_cnt17", {28'b0, cnt4}, 32'd1);
        end
        check("rep_cnt", {16'b0, xfer_count}, 32'd20);
        check("rep_ack", {31'b0, ack_tog}, 32'd0);
        check("rep_ovr", {31'b0, overrun}, 32'd0);
        check("wrap_cnt20", {28'b0, cnt4}, 32'd4);
        check("wrap_ack", {31'b0, ack4}, 32'd0);

        // Overrun: two extra toggles while held; both dropped.
        data_in = 8'h77;
        req_tog = ~req_tog;
        exp_q.push_back(8'h77);
        wait_valid();
        data_in = 8'h11;
        req_tog = ~req_tog;
        repeat (3) tick();
        data_in = 8'h22;
        req_tog = ~req_tog;
        repeat (4) tick();
        check("ovr_flag", {31'b0, overrun}, {31'b0, OVR_EN});
        check("ovr_data", {24'b0, out_data}, 32'h77);
        check("ovr_ack_hold", {31'b0, ack_tog}, {31'b0, exp_ack});
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        exp_cnt++;
        exp_ack = ~exp_ack;
        check("ovr_ack", {31'b0, ack_tog}, {31'b0, exp_ack});
        check("ovr_cnt", {16'b0, xfer_count}, exp_cnt);
        repeat (6) tick();
        check("ovr_no_extra_ack", {31'b0, ack_tog}, {31'b0, exp_ack});
        check("ovr_idle", {31'b0, out_valid}, 32'd0);
        check("ovr_sticky", {31'b0, overrun}, {31'b0, OVR_EN});
        check("ovr_sticky4", {31'b0, ovr4}, {31'b0, OVR_EN});

        // Reset while holding a payload: dropped, no ack ever issued.
        data_in = 8'h5A;
        req_tog = ~req_tog;
        exp_q.push_back(8'h5A);
        wait_valid();
        do_reset();
        check("mrst_valid", {31'b0, out_valid}, 32'd0);
        check("mrst_ack", {31'b0, ack_tog}, 32'd0);
        check("mrst_cnt", {16'b0, xfer_count}, 32'd0);
        check("mrst_ovr", {31'b0, overrun}, 32'd0);
        check("mrst_data", {24'b0, out_data}, 32'd0);
        repeat (8) tick();
        check("mrst_ack_late", {31'b0, ack_tog}, 32'd0);
        check("mrst_valid_late", {31'b0, out_valid}, 32'd0);
        check("mrst_valid4", {31'b0, valid4}, 32'd0);

        do_xfer(8'hC3, 2, 8'hC3, 1);
        check("post_data4", {24'b0, data4}, 32'hC3);
        check("sb_drain", exp_q.size(), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
